// File: rtl/udp_rx_pkg.sv
// Shared types and constants for the GMII UDP receiver.
package udp_rx_pkg;

    typedef enum logic [6:0] {
        st_idle     = 7'b000_0001,
        st_preamble = 7'b000_0010,
        st_eth_head = 7'b000_0100,
        st_ip_head  = 7'b000_1000,
        st_udp_head = 7'b001_0000,
        st_rx_data  = 7'b010_0000,
        st_rx_end   = 7'b100_0000
    } state_t;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
    localparam logic [7:0]  IPV4_VER_IHL  = 8'h45;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    // 0x55 bytes expected after the one that left idle
    localparam logic [15:0] PREAMBLE_TAIL = 16'd6;

    localparam logic [15:0] ETH_HEAD_LEN  = 16'd14;
    localparam logic [15:0] IP_HEAD_LEN   = 16'd20;
    localparam logic [15:0] UDP_HEAD_LEN  = 16'd8;

endpackage

// File: rtl/ip_csum_acc.sv
// Ones'-complement 16-bit accumulator; the end-around carry is folded on
// every add, so sum is always the folded result.
module ip_csum_acc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        add,
    input  logic [15:0] din,
    output logic [15:0] sum
);

    logic [15:0] acc;
    logic [16:0] raw;

    assign raw = {1'b0, acc} + {1'b0, din};
    assign sum = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (add) begin
            acc <= raw[15:0] + {15'd0, raw[16]};
        end
    end

endmodule

// File: rtl/udp_rx.sv
// GMII Ethernet II / IPv4 / UDP receiver delivering big-endian payload words.
// Optional IPv4 header checksum check: define UDP_RX_IP_CHECKSUM_EN.
module udp_rx
    import udp_rx_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd123}
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        rec_en,
    output logic [31:0] rec_data,
    output logic        rec_pkt_done,
    output logic [15:0] rec_byte_num,
    output logic [47:0] rec_src_mac,
    output logic [31:0] rec_src_ip
);

    state_t      state, next_state;
    logic [15:0] cnt;
    logic        skip_en, error_en;
    logic        count_en, word_done, commit_src;
    logic [39:0] des_mac;
    logic [47:0] mac_cand;
    logic [31:0] ip_cand;
    logic [15:0] udp_len;
    logic [15:0] data_num;
    logic        csum_err;

    assign data_num = udp_len - UDP_HEAD_LEN;

`ifdef UDP_RX_IP_CHECKSUM_EN
    logic [7:0]  csum_hi;
    logic [15:0] csum_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_hi <= '0;
        end else if (gmii_rx_dv && state == st_ip_head && !cnt[0]) begin
            csum_hi <= gmii_rxd;
        end
    end

    ip_csum_acc u_csum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == st_eth_head),
        .add   (gmii_rx_dv && state == st_ip_head && cnt[0]),
        .din   ({csum_hi, gmii_rxd}),
        .sum   (csum_sum)
    );

    assign csum_err = (csum_sum != 16'hFFFF);
`else
    assign csum_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= st_idle;
        end else begin
            state <= next_state;
        end
    end

    // Per-byte field checks: skip_en advances to the next section, error_en drops the frame
    always_comb begin
        skip_en  = 1'b0;
        error_en = 1'b0;
        if (gmii_rx_dv) begin
            case (state)
                st_idle: skip_en = (gmii_rxd == PREAMBLE_BYTE);
                st_preamble: begin
                    if (cnt < PREAMBLE_TAIL)        error_en = (gmii_rxd != PREAMBLE_BYTE);
                    else if (gmii_rxd == SFD_BYTE)  skip_en  = 1'b1;
                    else                            error_en = 1'b1;
                end
                st_eth_head: begin
                    if (cnt == 16'd5) begin
                        error_en = !(({des_mac, gmii_rxd} == BOARD_MAC) || ({des_mac, gmii_rxd} == '1));
                    end else if (cnt == 16'd12) begin
                        error_en = (gmii_rxd != ETH_TYPE_IPV4[15:8]);
                    end else if (cnt == ETH_HEAD_LEN - 16'd1) begin
                        error_en = (gmii_rxd != ETH_TYPE_IPV4[7:0]);
                        skip_en  = !error_en;
                    end
                end
                st_ip_head: begin
                    case (cnt)
                        16'd0:  error_en = (gmii_rxd != IPV4_VER_IHL);
                        16'd9:  error_en = (gmii_rxd != IP_PROTO_UDP);
                        16'd16: error_en = (gmii_rxd != BOARD_IP[31:24]);
                        16'd17: error_en = (gmii_rxd != BOARD_IP[23:16]);
                        16'd18: error_en = (gmii_rxd != BOARD_IP[15:8]);
                        16'd19: begin
                            error_en = (gmii_rxd != BOARD_IP[7:0]);
                            skip_en  = !error_en;
                        end
                        default: ;
                    endcase
                end
                st_udp_head: begin
                    if (cnt == 16'd0 && csum_err) begin
                        error_en = 1'b1;
                    end else if (cnt == UDP_HEAD_LEN - 16'd1) begin
                        error_en = (udp_len <= UDP_HEAD_LEN);
                        skip_en  = !error_en;
                    end
                end
                st_rx_data: skip_en = (cnt == data_num - 16'd1);
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            st_idle:   if (skip_en) next_state = st_preamble;
            st_rx_end: if (!gmii_rx_dv) next_state = st_idle;
            default: begin
                if (!gmii_rx_dv) begin
                    next_state = st_idle;
                end else if (error_en) begin
                    next_state = st_rx_end;
                end else if (skip_en) begin
                    case (state)
                        st_preamble: next_state = st_eth_head;
                        st_eth_head: next_state = st_ip_head;
                        st_ip_head:  next_state = st_udp_head;
                        st_udp_head: next_state = st_rx_data;
                        st_rx_data:  next_state = st_rx_end;
                        default:     next_state = st_idle;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        count_en   = gmii_rx_dv && (state != st_idle) && (state != st_rx_end);
        word_done  = 1'b0;
        commit_src = 1'b0;
        if (gmii_rx_dv && state == st_rx_data) begin
            word_done = (cnt[1:0] == 2'd3) || skip_en;
        end
        if (state == st_udp_head && next_state == st_rx_data) begin
            commit_src = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            des_mac      <= '0;
            mac_cand     <= '0;
            ip_cand      <= '0;
            udp_len      <= '0;
            rec_en       <= 1'b0;
            rec_data     <= '0;
            rec_pkt_done <= 1'b0;
            rec_byte_num <= '0;
            rec_src_mac  <= '0;
            rec_src_ip   <= '0;
        end else begin
            rec_en       <= 1'b0;
            rec_pkt_done <= 1'b0;
            if (next_state != state) cnt <= '0;
            else if (count_en)       cnt <= cnt + 16'd1;

            if (gmii_rx_dv) begin
                case (state)
                    st_eth_head: begin
                        if (cnt < 16'd5)       des_mac  <= {des_mac[31:0], gmii_rxd};
                        else if (cnt < 16'd12) mac_cand <= {mac_cand[39:0], gmii_rxd};
                    end
                    st_ip_head: begin
                        if (cnt >= 16'd12 && cnt < 16'd16) ip_cand <= {ip_cand[23:0], gmii_rxd};
                    end
                    st_udp_head: begin
                        if (cnt == 16'd4) udp_len[15:8] <= gmii_rxd;
                        if (cnt == 16'd5) udp_len[7:0]  <= gmii_rxd;
                    end
                    st_rx_data: begin
                        // Writing byte 0 of a word clears the rest, so a short last word is zero-filled
                        case (cnt[1:0])
                            2'd0:    rec_data        <= {gmii_rxd, 24'h0};
                            2'd1:    rec_data[23:16] <= gmii_rxd;
                            2'd2:    rec_data[15:8]  <= gmii_rxd;
                            default: rec_data[7:0]   <= gmii_rxd;
                        endcase
                        rec_en <= word_done;
                        if (skip_en) begin
                            rec_pkt_done <= 1'b1;
                            rec_byte_num <= data_num;
                        end
                    end
                    default: ;
                endcase
            end

            if (commit_src) begin
                rec_src_mac <= mac_cand;
                rec_src_ip  <= ip_cand;
            end
        end
    end

endmodule
